inst_fetch: RTL and testbench



---
 rtl/inst_fetch_pkg.sv | 24 ++
 rtl/inst_fetch_queue.sv | 59 +++++
 rtl/inst_fetch.sv | 178 +++++++++++++++++
 tb/tb_inst_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared opcodes, queue entry layout and immediate decoders for inst_fetch
package inst_fetch_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // One queue slot: fetched word, the PC it came from, and whether predecode redirected after it
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    localparam int IQ_W = $bits(iq_entry_t);

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - circular instruction FIFO with push/pop/clear and occupancy count
module inst_fetch_queue #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 65,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; clear wins over push/pop, pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (en_i) begin
            if (clr_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
            end
        end
    end

    // Entry storage; no reset because the count guards every read
    always_ff @(posedge clk) begin
        if (en_i && push_ok && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage with PC, one-outstanding request, predecode and instruction queue (optional BRANCH_PRED_EN)
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          IQ_DEPTH = 16,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          BHT_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    output logic        inst_in_flg,
    output logic [31:0] inst_addr,
    output logic        mem_reset,
    input  logic        ret_inst_in_flg,
    input  logic [31:0] ret_res,
    input  logic        clear_flg,
    input  logic [31:0] clear_pc,
    input  logic        dec_ready,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred_taken,
    input  logic        bht_upd_flg,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken
);

    localparam int            CW      = $clog2(IQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);
    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_WAIT  = 2'd1;
    localparam logic [1:0]    S_FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          req_q, req_d;
    logic          mrst_q, mrst_d;
    logic          iq_push, iq_pop, iq_clr, iq_empty, iq_full;
    logic [CW-1:0] iq_count, cnt_after_pop;
    iq_entry_t     push_ent, head_ent;
    logic [31:0]   next_pc;
    logic          pred_taken;
    logic          bht_hit;
    logic          unused_full;

`ifdef BRANCH_PRED_EN
    localparam int BHT_N = 1 << BHT_BITS;
    logic [1:0]          bht_q [BHT_N];
    logic [BHT_BITS-1:0] upd_idx;
    logic                unused_bht;

    assign upd_idx    = bht_upd_pc[BHT_BITS+1:2];
    assign bht_hit    = bht_q[pc_q[BHT_BITS+1:2]][1];
    assign unused_bht = ^{bht_upd_pc[31:BHT_BITS+2], bht_upd_pc[1:0]};

    // 2-bit saturating direction counters trained by resolved branches; lookup sees pre-update value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else if (rdy && bht_upd_flg) begin
            if (bht_upd_taken && bht_q[upd_idx] != 2'b11)
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            else if (!bht_upd_taken && bht_q[upd_idx] != 2'b00)
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
        end
    end
`else
    localparam int unused_bht_bits = BHT_BITS;
    logic unused_bht;

    assign bht_hit    = 1'b0;
    assign unused_bht = ^{bht_upd_flg, bht_upd_pc, bht_upd_taken};
`endif

    // A clear discards any same-cycle pop; FLUSH always sees an empty queue so no pop there either
    assign iq_pop        = !iq_empty && dec_ready && !clear_flg;
    assign cnt_after_pop = iq_count - CW'(iq_pop);
    assign push_ent      = '{inst: ret_res, pc: pc_q, pred: pred_taken};
    assign unused_full   = iq_full;

    // Predecode the returning word to pick the next fetch address
    always_comb begin
        next_pc    = pc_q + 32'd4;
        pred_taken = 1'b0;
        if (ret_res[6:0] == OP_JAL) begin
            next_pc    = pc_q + imm_j(ret_res);
            pred_taken = 1'b1;
        end else if (ret_res[6:0] == OP_BRANCH && bht_hit) begin
            next_pc    = pc_q + imm_b(ret_res);
            pred_taken = 1'b1;
        end
    end

    // Request sequencing: a request is only raised with a queue slot already reserved for its answer
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        mrst_d  = 1'b0;
        iq_push = 1'b0;
        iq_clr  = 1'b0;
        if (clear_flg) begin
            iq_clr  = 1'b1;
            pc_d    = clear_pc;
            req_d   = 1'b0;
            mrst_d  = 1'b1;
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cnt_after_pop < DEPTH_C) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ret_inst_in_flg) begin
                        iq_push = 1'b1;
                        pc_d    = next_pc;
                        if (cnt_after_pop + CW'(1) < DEPTH_C) begin
                            req_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                S_FLUSH: state_d = S_IDLE;
                default: begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // State registers; rdy low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            mrst_q  <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            mrst_q  <= mrst_d;
        end
    end

    inst_fetch_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (IQ_W)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (rdy),
        .clr_i   (iq_clr),
        .push_i  (iq_push),
        .data_i  (push_ent),
        .pop_i   (iq_pop),
        .data_o  (head_ent),
        .count_o (iq_count),
        .empty_o (iq_empty),
        .full_o  (iq_full)
    );

    assign inst_in_flg   = req_q;
    assign inst_addr     = pc_q;
    assign mem_reset     = mrst_q;
    assign iq_valid      = !iq_empty;
    assign iq_inst       = head_ent.inst;
    assign iq_pc         = head_ent.pc;
    assign iq_pred_taken = head_ent.pred;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch against a transaction-level queue model
module tb_inst_fetch;

    localparam int          DEPTH = 16;
    localparam logic [31:0] RPC   = 32'h0;
    localparam int          BB    = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        ret = 1'b0, clr = 1'b0, dec = 1'b0;
    logic        upd = 1'b0, upd_taken = 1'b0;
    logic [31:0] res = '0, cpc = '0, upd_pc = '0;
    logic        inst_in_flg, mem_reset, iq_valid, iq_pred_taken;
    logic [31:0] inst_addr, iq_inst, iq_pc;

    always #5 clk = ~clk;

    inst_fetch #(.IQ_DEPTH(DEPTH), .RESET_PC(RPC), .BHT_BITS(BB)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .inst_in_flg(inst_in_flg), .inst_addr(inst_addr), .mem_reset(mem_reset),
        .ret_inst_in_flg(ret), .ret_res(res),
        .clear_flg(clr), .clear_pc(cpc), .dec_ready(dec),
        .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pred_taken(iq_pred_taken),
        .bht_upd_flg(upd), .bht_upd_pc(upd_pc), .bht_upd_taken(upd_taken)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = RPC;
    bit          m_req = 0;
    bit          m_flush = 0;
    int          m_bht[1 << BB];

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        return 32'($signed(v << (32 - bits)) >>> (32 - bits));
    endfunction

    function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                    output logic [31:0] npc, output logic pred);
        npc  = pc + 32'd4;
        pred = 1'b0;
        if (inst[6:0] == 7'h6f) begin
            npc  = pc + sext({11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
            pred = 1'b1;
        end
`ifdef BRANCH_PRED_EN
        else if (inst[6:0] == 7'h63 && m_bht[pc[BB+1:2]] >= 2) begin
            npc  = pc + sext({19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
            pred = 1'b1;
        end
`endif
    endfunction

    task automatic model_step();
        ent_t        e;
        logic [31:0] npc;
        logic        pr;
        if (!rdy) return;
        if (clr) begin
            mq.delete();
            m_pc    = cpc;
            m_req   = 0;
            m_flush = 1;
        end else if (m_flush) begin
            m_flush = 0;
        end else begin
            if (mq.size() > 0 && dec) void'(mq.pop_front());
            if (m_req && ret) begin
                predict(res, m_pc, npc, pr);
                e.inst = res; e.pc = m_pc; e.pred = pr;
                mq.push_back(e);
                m_pc  = npc;
                m_req = mq.size() < DEPTH;
            end else if (!m_req) begin
                m_req = mq.size() < DEPTH;
            end
        end
`ifdef BRANCH_PRED_EN
        if (upd) begin
            if (upd_taken && m_bht[upd_pc[BB+1:2]] < 3) m_bht[upd_pc[BB+1:2]]++;
            else if (!upd_taken && m_bht[upd_pc[BB+1:2]] > 0) m_bht[upd_pc[BB+1:2]]--;
        end
`endif
    endtask

    task automatic compare_all();
        check("req", inst_in_flg, m_req);
        if (m_req) check("addr", inst_addr, m_pc);
        check("mem_reset", mem_reset, m_flush);
        check("iq_valid", iq_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("iq_inst", iq_inst, mq[0].inst);
            check("iq_pc", iq_pc, mq[0].pc);
            check("iq_pred", iq_pred_taken, mq[0].pred);
        end
    endtask

    task automatic cyc(input bit r, input logic [31:0] d, input bit dr, input bit c, input logic [31:0] cp);
        ret = r; res = d; dec = dr; clr = c; cpc = cp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 3))
            0:       w = {w[31:7], 7'h13};
            1:       begin w = {w[31:7], 7'h6f}; w[21] = 1'b0; end
            default: begin w = {w[31:7], 7'h63}; w[8] = 1'b0; end
        endcase
        return w;
    endfunction

    initial begin
        for (int i = 0; i < (1 << BB); i++) m_bht[i] = 1;
        @(negedge clk);
        @(negedge clk);
        check("rst.req", inst_in_flg, 1'b0);
        check("rst.mem_reset", mem_reset, 1'b0);
        check("rst.iq_valid", iq_valid, 1'b0);
        check("rst.addr", inst_addr, RPC);
        rst_n = 1'b1;

        cyc(0, 0, 0, 0, 0);
        check("run.first_addr", inst_addr, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h13, 0, 0, 0);
        check("run.addr12", inst_addr, 32'hc);
        check("run.head_pc", iq_pc, 32'h0);
        check("run.head_pred", iq_pred_taken, 1'b0);
        cyc(1, 32'h13, 0, 0, 0);
        cyc(1, 32'h0080006F, 0, 0, 0);
        check("jal.addr", inst_addr, 32'h18);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        check("jal.head_pc", iq_pc, 32'h10);
        check("jal.head_pred", iq_pred_taken, 1'b1);

        for (int i = 0; i < 15; i++) cyc(1, 32'h13, 0, 0, 0);
        check("full.req_off", inst_in_flg, 1'b0);
        cyc(0, 0, 0, 0, 0);
        check("full.req_held_off", inst_in_flg, 1'b0);
        cyc(0, 0, 1, 0, 0);
        check("full.reissue", inst_in_flg, 1'b1);

        cyc(1, 32'h13, 0, 1, 32'h100);
        check("clr.mem_reset_on", mem_reset, 1'b1);
        check("clr.iq_empty", iq_valid, 1'b0);
        cyc(0, 0, 0, 0, 0);
        check("clr.mem_reset_off", mem_reset, 1'b0);
        cyc(0, 0, 0, 0, 0);
        check("clr.req", inst_in_flg, 1'b1);
        check("clr.addr", inst_addr, 32'h100);

        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0);
            check("stall.req", inst_in_flg, 1'b1);
            check("stall.addr", inst_addr, 32'h100);
        end
        cyc(1, 32'h13, 0, 0, 0);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, rand_inst(), 1, 0, 0);
            check("frz.addr", inst_addr, 32'h104);
            check("frz.head_pc", iq_pc, 32'h100);
        end
        rdy = 1'b1;

        upd = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
        cyc(0, 0, 1, 1, 32'h40);
        cyc(0, 0, 0, 0, 0);
        upd = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h00000863, 0, 0, 0);
`ifdef BRANCH_PRED_EN
        check("bht.addr", inst_addr, 32'h50);
        check("bht.pred", iq_pred_taken, 1'b1);
`else
        check("bht.addr", inst_addr, 32'h44);
        check("bht.pred", iq_pred_taken, 1'b0);
`endif

        for (int n = 0; n < 3000; n++) begin
            bit dr;
            rdy       = ($urandom_range(0, 9) != 0);
            upd       = ($urandom_range(0, 4) == 0);
            upd_taken = $urandom_range(0, 1);
            upd_pc    = $urandom_range(0, 1) ? m_pc : ($urandom() & 32'hffff_fffc);
            dr        = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc((m_req || m_flush) && $urandom_range(0, 1), rand_inst(), dr,
                $urandom_range(0, 49) == 0, $urandom() & 32'hffff_fffc);
        end
        upd = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("arst.req", inst_in_flg, 1'b0);
        check("arst.iq_valid", iq_valid, 1'b0);
        check("arst.mem_reset", mem_reset, 1'b0);
        check("arst.addr", inst_addr, RPC);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
